// File: rtl/store.sv
// AXI4 single-beat write initiator: queues core store requests in a small FIFO
// and issues them one at a time over AW/W, reporting each B response back to the core.
module store #(
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int DEPTH                   = 4
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic                                 I_VALID,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]        I_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]        I_DATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]      I_STRB,
  output logic                                 MEM_WAIT,
  output logic                                 O_DONE,
  output logic [1:0]                           O_RESP,
  output logic                                 O_ERR,
  output logic                                 O_IDLE,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
  output logic [7:0]                           M_AXI_AWLEN,
  output logic [2:0]                           M_AXI_AWSIZE,
  output logic [1:0]                           M_AXI_AWBURST,
  output logic                                 M_AXI_AWLOCK,
  output logic [3:0]                           M_AXI_AWCACHE,
  output logic [2:0]                           M_AXI_AWPROT,
  output logic [3:0]                           M_AXI_AWQOS,
  output logic                                 M_AXI_AWUSER,
  output logic                                 M_AXI_AWVALID,
  input  logic                                 M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
  output logic                                 M_AXI_WLAST,
  output logic                                 M_AXI_WUSER,
  output logic                                 M_AXI_WVALID,
  input  logic                                 M_AXI_WREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_BID,
  input  logic [1:0]                           M_AXI_BRESP,
  input  logic                                 M_AXI_BUSER,
  input  logic                                 M_AXI_BVALID,
  output logic                                 M_AXI_BREADY
);

  localparam int A_W   = C_M_AXI_ADDR_WIDTH;
  localparam int D_W   = C_M_AXI_DATA_WIDTH;
  localparam int S_W   = C_M_AXI_DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP} state_t;

  state_t               r_state, w_next;
  logic [A_W-3:0]       r_mem_addr [DEPTH];
  logic [D_W-1:0]       r_mem_data [DEPTH];
  logic [S_W-1:0]       r_mem_strb [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic [A_W-3:0]       r_awaddr;
  logic [D_W-1:0]       r_wdata;
  logic [S_W-1:0]       r_wstrb;
  logic                 r_aw_done, r_w_done, r_done, r_err;
  logic [1:0]           r_resp;
  logic                 w_full, w_empty, w_push, w_pop;
  logic                 w_awvalid, w_wvalid, w_bready;
  logic                 w_aw_hs, w_w_hs, w_b_hs;
  logic                 w_unused;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = I_VALID && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_aw_hs = w_awvalid && M_AXI_AWREADY;
  assign w_w_hs  = w_wvalid && M_AXI_WREADY;
  assign w_b_hs  = w_bready && M_AXI_BVALID;
  // Byte-lane bits of the address and the B sideband fields carry no information here.
  assign w_unused = ^{M_AXI_BID, M_AXI_BUSER, I_ADDR[1:0]};

  // FIFO storage and the issued-request registers hold data only; no reset needed.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= I_ADDR[A_W-1:2];
      r_mem_data[r_wr_ptr] <= I_DATA;
      r_mem_strb[r_wr_ptr] <= I_STRB;
    end
    if (w_pop) begin
      r_awaddr <= r_mem_addr[r_rd_ptr];
      r_wdata  <= r_mem_data[r_rd_ptr];
      r_wstrb  <= r_mem_strb[r_rd_ptr];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_ADDR;
      S_ADDR:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = S_RESP;
      S_RESP:  if (M_AXI_BVALID) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Each VALID drops independently once its own handshake has been recorded.
  always_comb begin
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    unique case (r_state)
      S_ADDR: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      S_RESP:  w_bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_resp    <= 2'b00;
      r_err     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      r_done <= w_b_hs;
      if (w_b_hs) begin
        r_resp <= M_AXI_BRESP;
        if (M_AXI_BRESP[1]) r_err <= 1'b1;
      end
    end
  end

  assign MEM_WAIT      = w_full;
  assign O_DONE        = r_done;
  assign O_RESP        = r_resp;
  assign O_ERR         = r_err;
  assign O_IDLE        = w_empty && (r_state == S_IDLE);
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = {r_awaddr, 2'b00};
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 1'b0;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WLAST   = w_wvalid;
  assign M_AXI_WUSER   = 1'b0;
  assign M_AXI_WVALID  = w_wvalid;
  assign M_AXI_BREADY  = w_bready;

endmodule

// File: tb/tb_store.sv
// Directed bench for store: a small AXI write slave answers each AW+W pair with a
// B response one cycle after both are taken, using a per-write response table.
module tb_store;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_addr, i_data;
  logic [3:0]  i_strb;
  logic        mem_wait, o_done, o_err, o_idle;
  logic [1:0]  o_resp;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic        awlock, awuser, awvalid, aw_rdy;
  logic [3:0]  awcache, awqos;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wuser, wvalid, w_rdy;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic        got_aw, got_w;
  int          b_cnt = 0;
  int          aw_n = 0;
  int          w_n = 0;
  int          done_cnt = 0;
  logic [1:0]  resp_tab [64];
  logic [31:0] aw_log [64];
  logic [31:0] w_log [64];

  always #5 clk = ~clk;

  store #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_THREAD_ID_WIDTH(1), .DEPTH(4)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .I_VALID(i_valid), .I_ADDR(i_addr), .I_DATA(i_data), .I_STRB(i_strb),
    .MEM_WAIT(mem_wait), .O_DONE(o_done), .O_RESP(o_resp), .O_ERR(o_err), .O_IDLE(o_idle),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(aw_rdy),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(w_rdy),
    .M_AXI_BID(1'b0), .M_AXI_BRESP(bresp), .M_AXI_BUSER(1'b0),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      got_aw <= 1'b0;
      got_w  <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= 2'b00;
    end else begin
      if (awvalid && aw_rdy) begin
        got_aw <= 1'b1;
        aw_log[aw_n] <= awaddr;
        aw_n <= aw_n + 1;
      end
      if (wvalid && w_rdy) begin
        got_w <= 1'b1;
        w_log[w_n] <= wdata;
        w_n <= w_n + 1;
      end
      if (got_aw && got_w && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= resp_tab[b_cnt];
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_cnt  <= b_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (o_done) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (o_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(o_done), 64'd1);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    i_valid = 1'b1;
    i_addr  = a;
    i_data  = d;
    i_strb  = s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "timeout");
  end

  initial begin
    int base_aw, base_done, n, k;
    logic [1:0] rs [3];
    logic       er [3];
    for (int i = 0; i < 64; i++) resp_tab[i] = 2'b00;
    rst_n = 1'b0; i_valid = 1'b0; i_addr = '0; i_data = '0; i_strb = '0;
    aw_rdy = 1'b0; w_rdy = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_awvalid", 64'(awvalid), 64'd0);
    chk("rst_wvalid",  64'(wvalid),  64'd0);
    chk("rst_bready",  64'(bready),  64'd0);
    chk("rst_done",    64'(o_done),  64'd0);
    chk("rst_resp",    64'(o_resp),  64'd0);
    chk("rst_err",     64'(o_err),   64'd0);
    chk("rst_memwait", 64'(mem_wait), 64'd0);
    chk("rst_idle",    64'(o_idle),  64'd1);
    rst_n = 1'b1;
    tick();

    // Single write, zero-wait slave
    aw_rdy = 1'b1; w_rdy = 1'b1;
    drive(32'h100, 32'hDEADBEEF, 4'hF);
    tick();
    i_valid = 1'b0;
    chk("t1_aw_n0", 64'(awvalid), 64'd0);
    chk("t1_busy", 64'(o_idle), 64'd0);
    tick();
    chk("t1_awvalid", 64'(awvalid), 64'd1);
    chk("t1_wvalid",  64'(wvalid),  64'd1);
    chk("t1_awaddr",  64'(awaddr),  64'h100);
    chk("t1_wdata",   64'(wdata),   64'hDEADBEEF);
    chk("t1_wstrb",   64'(wstrb),   64'hF);
    chk("t1_wlast",   64'(wlast),   64'd1);
    chk("t1_awlen",   64'(awlen),   64'd0);
    chk("t1_awsize",  64'(awsize),  64'd2);
    chk("t1_awburst", 64'(awburst), 64'd1);
    chk("t1_awcache", 64'(awcache), 64'h3);
    tick();
    chk("t1_aw_drop", 64'(awvalid), 64'd0);
    chk("t1_bready",  64'(bready),  64'd1);
    chk("t1_done_n2", 64'(o_done),  64'd0);
    tick();
    chk("t1_done_n3", 64'(o_done),  64'd0);
    tick();
    chk("t1_done_n4", 64'(o_done),  64'd1);
    chk("t1_resp",    64'(o_resp),  64'd0);
    chk("t1_idle",    64'(o_idle),  64'd1);
    tick();
    chk("t1_done_pulse", 64'(o_done), 64'd0);

    // AWREADY stalled while W is accepted at once
    aw_rdy = 1'b0; w_rdy = 1'b1;
    drive(32'h204, 32'h11112222, 4'h3);
    tick();
    i_valid = 1'b0;
    tick();
    chk("t2_both_valid", 64'({awvalid, wvalid}), 64'h3);
    tick();
    chk("t2_w_drop",   64'(wvalid),  64'd0);
    chk("t2_aw_hold",  64'(awvalid), 64'd1);
    chk("t2_no_bready", 64'(bready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_aw_stall", 64'({awvalid, bready}), 64'h2);
      chk("t2_aw_stable", 64'(awaddr), 64'h204);
    end
    aw_rdy = 1'b1;
    tick();
    chk("t2_aw_taken", 64'(awvalid), 64'd0);
    chk("t2_bready",   64'(bready),  64'd1);
    wait_done("t2_done");
    chk("t2_resp", 64'(o_resp), 64'd0);
    tick();

    // FIFO fill, MEM_WAIT, held request, in-order completion
    aw_rdy = 1'b0; w_rdy = 1'b1;
    base_aw = aw_n;
    base_done = done_cnt;
    drive(32'h300, 32'hA0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(32'h310 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF);
      tick();
    end
    chk("t3_full", 64'(mem_wait), 64'd1);
    drive(32'h320, 32'hB4, 4'hF);
    tick(); tick();
    chk("t3_still_full", 64'(mem_wait), 64'd1);
    aw_rdy = 1'b1;
    n = 0;
    while (mem_wait && n < 50) begin
      tick();
      n++;
    end
    chk("t3_space", 64'(mem_wait), 64'd0);
    tick();
    i_valid = 1'b0;
    n = 0;
    while ((done_cnt - base_done) < 6 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk("t3_done_cnt", 64'(done_cnt - base_done), 64'd6);
    chk("t3_aw_cnt",   64'(aw_n - base_aw), 64'd6);
    chk("t3_ord0", 64'(aw_log[base_aw]), 64'h300);
    chk("t3_ord1", 64'(aw_log[base_aw + 1]), 64'h310);
    chk("t3_ord3", 64'(aw_log[base_aw + 3]), 64'h318);
    chk("t3_ord5", 64'(aw_log[base_aw + 5]), 64'h320);
    chk("t3_wd2",  64'(w_log[base_aw + 2]), 64'hB1);
    chk("t3_wd5",  64'(w_log[base_aw + 5]), 64'hB4);
    chk("t3_idle", 64'(o_idle), 64'd1);

    // SLVERR on the second of three writes
    chk("t4_err_clear", 64'(o_err), 64'd0);
    resp_tab[b_cnt + 1] = 2'b10;
    base_aw = aw_n;
    for (int i = 0; i < 3; i++) begin
      drive(32'h500 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
      tick();
    end
    i_valid = 1'b0;
    k = 0; n = 0;
    while (k < 3 && n < 100) begin
      if (o_done) begin
        rs[k] = o_resp;
        er[k] = o_err;
        k++;
      end
      tick();
      n++;
    end
    chk("t4_ndone", 64'(k), 64'd3);
    chk("t4_resp1", 64'(rs[0]), 64'd0);
    chk("t4_err1",  64'(er[0]), 64'd0);
    chk("t4_resp2", 64'(rs[1]), 64'h2);
    chk("t4_err2",  64'(er[1]), 64'd1);
    chk("t4_resp3", 64'(rs[2]), 64'd0);
    chk("t4_err3",  64'(er[2]), 64'd1);
    chk("t4_w3_issued", 64'(aw_log[base_aw + 2]), 64'h508);
    tick(); tick();
    chk("t4_err_sticky", 64'(o_err), 64'd1);

    // Low address bits are masked on AWADDR
    drive(32'h203, 32'h77, 4'h1);
    tick();
    i_valid = 1'b0;
    tick();
    chk("t5_awaddr", 64'(awaddr), 64'h200);
    wait_done("t5_done");
    tick();

    // Asynchronous reset in S_ADDR with two requests queued
    aw_rdy = 1'b0; w_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h600 + 32'(4 * i), 32'hD0 + 32'(i), 4'hF);
      tick();
    end
    i_valid = 1'b0;
    chk("t6_pre_awvalid", 64'(awvalid), 64'd1);
    chk("t6_pre_idle",    64'(o_idle),  64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_awvalid", 64'(awvalid), 64'd0);
    chk("t6_wvalid",  64'(wvalid),  64'd0);
    chk("t6_bready",  64'(bready),  64'd0);
    chk("t6_idle",    64'(o_idle),  64'd1);
    chk("t6_memwait", 64'(mem_wait), 64'd0);
    chk("t6_err",     64'(o_err),   64'd0);
    chk("t6_done_resp", 64'({o_done, o_resp}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    aw_rdy = 1'b1; w_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_reissue", 64'({awvalid, o_idle}), 64'h1);
    end
    drive(32'h700, 32'h55, 4'hF);
    tick();
    i_valid = 1'b0;
    chk("t6_new_wait", 64'(awvalid), 64'd0);
    tick();
    chk("t6_new_awvalid", 64'(awvalid), 64'd1);
    chk("t6_new_awaddr",  64'(awaddr),  64'h700);
    wait_done("t6_new_done");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
